// File: rtl/uart_scheduler.sv
// rtl/uart_scheduler.sv - shares one uart between NUM_REQ round-robin transmitters and buffers its receive path
module uart_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            uart_start,
  output logic [DATA_WIDTH-1:0]           uart_datatx,
  input  logic                            uart_ready,
  input  logic                            uart_rcvd,
  input  logic                            uart_rx_err,
  input  logic [DATA_WIDTH-1:0]           uart_datarx,
  output logic                            uart_rxack,
  output logic                            rx_valid,
  output logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_ready,
  output logic                            rx_overrun,
  output logic                            rx_err,
  output logic                            tx_fault,
  output logic                            busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;

  tx_state_t             state;
  logic [IW-1:0]         last;
  logic [IW-1:0]         win;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] win_data;
  logic [1:0]            busy_cnt;
  logic                  ack_pending;
  logic                  rx_capture;

  // Scan from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    int idx;
    idx = 0;
    win = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IW'(idx)]) win = IW'(idx);
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= IW'(NUM_REQ - 1);
      gnt         <= '0;
      uart_start  <= 1'b0;
      uart_datatx <= '0;
      busy        <= 1'b0;
      busy_cnt    <= 2'd0;
      tx_fault    <= 1'b0;
    end else begin
      gnt        <= '0;
      uart_start <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_ready && (|req)) begin
            uart_datatx <= win_data;
            last        <= win;
            gnt         <= win_onehot;
            uart_start  <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          busy_cnt <= 2'd0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!uart_ready) begin
            state <= WAIT_DONE;
          end else begin
            busy_cnt <= busy_cnt + 2'd1;
            // Third cycle with ready still high: the uart never took the word.
            if (busy_cnt == 2'd2) begin
              tx_fault <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (uart_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // rcvd stays high until the uart sees rxack, so one capture per frame.
  assign rx_capture = uart_rcvd && !ack_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_rxack  <= 1'b0;
      ack_pending <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_overrun  <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_err      <= uart_rx_err;
      uart_rxack  <= rx_capture;
      ack_pending <= rx_capture;
      if (rx_capture) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= uart_datarx;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_scheduler.sv
// tb/tb_uart_scheduler.sv - self-checking bench for uart_scheduler with a behavioural uart stand-in
module tb_uart_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FL = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           uart_start;
  logic [W-1:0]   uart_datatx;
  logic           uart_ready = 1'b1;
  logic           uart_rcvd;
  logic           uart_rx_err;
  logic [W-1:0]   uart_datarx;
  logic           uart_rxack;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           rx_ready;
  logic           rx_overrun;
  logic           rx_err;
  logic           tx_fault;
  logic           busy;

  uart_scheduler #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .uart_start(uart_start), .uart_datatx(uart_datatx), .uart_ready(uart_ready),
    .uart_rcvd(uart_rcvd), .uart_rx_err(uart_rx_err), .uart_datarx(uart_datarx),
    .uart_rxack(uart_rxack), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_err(rx_err), .tx_fault(tx_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Stand-in uart: goes busy for FL cycles after each start unless stuck.
  bit stuck   = 1'b0;
  bit measure = 1'b0;
  int cnt = 0;
  int starts = 0;
  bit armed = 1'b0;
  int idle = 0;
  int max_gap = 0;

  always @(negedge clk) begin
    if (reset) begin
      uart_ready = 1'b1;
      cnt = 0;
      armed = 1'b0;
      idle = 0;
    end else begin
      if (uart_start) begin
        starts++;
        if (measure && armed && idle > max_gap) max_gap = idle;
        armed = 1'b0;
        idle = 0;
      end else if (armed) begin
        idle++;
      end
      if (uart_start && !stuck) begin
        uart_ready = 1'b0;
        cnt = FL;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          uart_ready = 1'b1;
          armed = 1'b1;
          idle = 0;
        end
      end
    end
  end

  logic [W-1:0] lanes [N];
  int m_last;

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = lanes[i];
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 80; t++) begin
      if (!busy) break;
      tick();
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_start"}, 32'(uart_start), 32'd0);
    chk({tag, "_datatx"}, 32'(uart_datatx), 32'd0);
    chk({tag, "_rxack"}, 32'(uart_rxack), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_overrun"}, 32'(rx_overrun), 32'd0);
    chk({tag, "_rx_err"}, 32'(rx_err), 32'd0);
    chk({tag, "_tx_fault"}, 32'(tx_fault), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    uart_rcvd = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_last = N - 1;
  endtask

  // Captures a two-cycle rcvd frame; returns rxack as seen in the cycle after rcvd rose.
  task automatic rx_frame(input logic [W-1:0] v, output logic ack);
    uart_datarx = v;
    uart_rcvd = 1'b1;
    tick();
    ack = uart_rxack;
    tick();
    uart_rcvd = 1'b0;
    tick();
  endtask

  // One-word buffer model: a frame is delivered on the first cycle rcvd is seen.
  bit           mv;
  logic [W-1:0] md;
  bit           movr;

  task automatic rx_step(input bit rc, input bit first, input logic [W-1:0] v, input bit rdy);
    bit deliver;
    uart_rcvd = rc;
    uart_datarx = v;
    rx_ready = rdy;
    deliver = rc && first;
    if (deliver) begin
      if (!mv || rdy) begin
        md = v;
        mv = 1'b1;
      end else begin
        movr = 1'b1;
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    tick();
    chk("rnd_rx_valid", 32'(rx_valid), 32'(mv));
    chk("rnd_rx_data", 32'(rx_data), 32'(md));
    chk("rnd_overrun", 32'(rx_overrun), 32'(movr));
    chk("rnd_rxack", 32'(uart_rxack), 32'(deliver));
  endtask

  bit           ok;
  int           w;
  int           s0;
  logic [N-1:0] nb;
  logic         ack;

  initial begin
    reset = 1'b1;
    req = '0;
    req_data = '0;
    uart_rcvd = 1'b0;
    uart_rx_err = 1'b0;
    uart_datarx = '0;
    rx_ready = 1'b0;
    for (int i = 0; i < N; i++) lanes[i] = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    m_last = N - 1;

    // Single request from requester 2
    lanes[2] = 8'hA5;
    pack();
    req = 4'b0100;
    wait_gnt(ok);
    if (ok) begin
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_start", 32'(uart_start), 32'd1);
      chk("single_datatx", 32'(uart_datatx), 32'hA5);
      chk("single_busy", 32'(busy), 32'd1);
    end
    m_last = 2;
    tick();
    req = '0;
    chk("single_gnt_pulse", 32'(gnt), 32'd0);
    chk("single_start_pulse", 32'(uart_start), 32'd0);
    wait_idle();
    chk("single_ready_at_idle", 32'(uart_ready), 32'd1);
    chk("single_datatx_hold", 32'(uart_datatx), 32'hA5);

    // Fairness from reset pointer: all requesters held
    do_reset();
    for (int i = 0; i < N; i++) lanes[i] = W'($urandom);
    pack();
    measure = 1'b1;
    s0 = starts;
    req = 4'hF;
    for (int g = 0; g < 2 * N; g++) begin
      wait_gnt(ok);
      chk("fair_gnt", 32'(gnt), 32'(1 << (g % N)));
      chk("fair_datatx", 32'(uart_datatx), 32'(lanes[g % N]));
      m_last = g % N;
      tick();
      if (g == 2 * N - 1) req = '0;
    end
    wait_idle();
    measure = 1'b0;
    chk("fair_starts", 32'(starts - s0), 32'(2 * N));
    chk("fair_gap_le1", 32'(max_gap <= 1), 32'd1);

    // Randomized arbitration against the round-robin model
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) lanes[i] = W'($urandom);
    pack();
    for (int it = 0; it < 24; it++) begin
      wait_gnt(ok);
      w = rr_pick(req, m_last);
      chk("rnd_gnt", 32'(gnt), 32'(1 << w));
      chk("rnd_datatx", 32'(uart_datatx), 32'(lanes[w]));
      m_last = w;
      tick();
      req[w] = 1'b0;
      nb = N'($urandom) & ~req;
      for (int i = 0; i < N; i++) if (nb[i]) lanes[i] = W'($urandom);
      req = req | nb;
      if (req == '0) begin
        w = $urandom_range(0, N - 1);
        req[w] = 1'b1;
        lanes[w] = W'($urandom);
      end
      pack();
    end
    req = '0;
    wait_idle();

    // RX loopback word, consumer ready
    rx_ready = 1'b1;
    uart_datarx = 8'h3C;
    uart_rcvd = 1'b1;
    tick();
    chk("lb_rx_valid", 32'(rx_valid), 32'd1);
    chk("lb_rx_data", 32'(rx_data), 32'h3C);
    chk("lb_rxack", 32'(uart_rxack), 32'd1);
    tick();
    uart_rcvd = 1'b0;
    chk("lb_rx_valid_once", 32'(rx_valid), 32'd0);
    chk("lb_rxack_once", 32'(uart_rxack), 32'd0);
    tick();
    chk("lb_no_recapture", 32'(rx_valid), 32'd0);
    chk("lb_overrun", 32'(rx_overrun), 32'd0);
    uart_rx_err = 1'b1;
    tick();
    chk("rx_err_set", 32'(rx_err), 32'd1);
    uart_rx_err = 1'b0;
    tick();
    chk("rx_err_clr", 32'(rx_err), 32'd0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    rx_frame(8'h11, ack);
    chk("ovr_ack1", 32'(ack), 32'd1);
    chk("ovr_data1", 32'(rx_data), 32'h11);
    chk("ovr_clean", 32'(rx_overrun), 32'd0);
    rx_frame(8'h22, ack);
    chk("ovr_ack2", 32'(ack), 32'd1);
    chk("ovr_data2", 32'(rx_data), 32'h11);
    chk("ovr_flag", 32'(rx_overrun), 32'd1);
    chk("ovr_valid", 32'(rx_valid), 32'd1);

    // Randomized RX traffic against the buffer model
    do_reset();
    mv = 1'b0;
    md = '0;
    movr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      bit f;
      logic [W-1:0] v;
      f = ($urandom_range(0, 2) != 0);
      v = W'($urandom);
      rx_step(f, 1'b1, v, 1'($urandom));
      rx_step(f, 1'b0, v, 1'($urandom));
      rx_step(1'b0, 1'b0, v, 1'($urandom));
    end

    // Uart never goes busy: fault after three WAIT_BUSY cycles
    do_reset();
    rx_ready = 1'b0;
    stuck = 1'b1;
    lanes[0] = 8'h5A;
    pack();
    req = 4'b0001;
    wait_gnt(ok);
    tick();
    req = '0;
    chk("fault_busy1", 32'(busy), 32'd1);
    chk("fault_early1", 32'(tx_fault), 32'd0);
    tick();
    chk("fault_early2", 32'(tx_fault), 32'd0);
    tick();
    chk("fault_early3", 32'(tx_fault), 32'd0);
    tick();
    chk("fault_set", 32'(tx_fault), 32'd1);
    chk("fault_idle", 32'(busy), 32'd0);
    tick();
    chk("fault_sticky", 32'(tx_fault), 32'd1);
    stuck = 1'b0;

    // Reset in the middle of a frame and a receive
    do_reset();
    lanes[3] = 8'hC3;
    pack();
    req = 4'b1000;
    wait_gnt(ok);
    chk("mid_gnt", 32'(gnt), 32'h8);
    tick();
    req = '0;
    uart_datarx = 8'h77;
    uart_rcvd = 1'b1;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rxack", 32'(uart_rxack), 32'd1);
    reset = 1'b1;
    uart_rcvd = 1'b0;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    m_last = N - 1;
    req = 4'hF;
    wait_gnt(ok);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_scheduler.md
# uart_scheduler

Controller that shares one `uart` instance between NUM_REQ transmit requesters and sequences its receive handshake. It has two parts. The TX side arbitrates round-robin, launches each word with a single-cycle `uart_start`, and tracks `uart_ready` until the frame is finished. The RX side captures each completed frame into a one-word buffer with a valid/ready interface, issues the `rxack` pulse, and flags overruns. It sits between the `uart` and the system's producer/consumer logic.

## Interface
- NUM_REQ, 4, number of TX requesters (2..8)
- DATA_WIDTH, 8, word width; must match the `uart` DATA_WIDTH (≤32)
- clk  in  1  clock (same 10x-baud clock as `uart`)
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester TX request; level, held until granted
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: requester's word accepted
- uart_start  out  1  to `uart` start
- uart_datatx  out  DATA_WIDTH  to `uart` datatx
- uart_ready  in  1  from `uart` ready
- uart_rcvd  in  1  from `uart` rcvd
- uart_rx_err  in  1  from `uart` rx_err
- uart_datarx  in  DATA_WIDTH  from `uart` datarx
- uart_rxack  out  1  to `uart` rxack
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_data  out  DATA_WIDTH  received word
- rx_ready  in  1  consumer accepts rx_data when rx_valid
- rx_overrun  out  1  sticky: a frame was dropped because the buffer was full
- rx_err  out  1  registered copy of uart_rx_err
- tx_fault  out  1  sticky: uart failed to go busy after start
- busy  out  1  TX FSM not in IDLE

## Operation
- Reset values: gnt=0, uart_start=0, uart_datatx=0, uart_rxack=0, rx_valid=0, rx_data=0, rx_overrun=0, rx_err=0, tx_fault=0, busy=0. TX FSM=IDLE. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- TX FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if uart_ready=1 and |req:
  - Winner = first set req scanning last+1, last+2, … with wrap modulo NUM_REQ.
  - Capture req_data[winner] into uart_datatx, set last=winner, go to LAUNCH.
- LAUNCH (exactly 1 cycle): uart_start=1 and gnt[winner]=1. Go to WAIT_BUSY with a 2-bit timeout counter cleared.
- WAIT_BUSY:
  - uart_ready=0 → WAIT_DONE.
  - Otherwise increment the counter. If the counter reaches 3 with uart_ready still 1, set tx_fault and go to IDLE.
- WAIT_DONE: when uart_ready=1, go to IDLE. The next arbitration may happen in that same IDLE cycle.
- uart_datatx holds its value from capture until the next capture.
- busy = (state != IDLE).
- RX side:
  - A capture occurs when uart_rcvd=1 and no ack is pending.
  - On capture, assert uart_rxack (registered, 1 cycle) and set a 1-cycle ack-pending flag. This blocks recapture while uart_rcvd is still high during the cycle in which the ack is seen.
  - If the buffer is empty, or being consumed in the same cycle (rx_valid & rx_ready): rx_data <= uart_datarx, rx_valid <= 1.
  - Else: drop the word, set rx_overrun. rx_data is unchanged.
  - rx_valid & rx_ready with no capture → rx_valid <= 0.
- rx_err <= uart_rx_err every cycle. rx_overrun and tx_fault clear only on reset.

## Timing
- Req sampled in IDLE at edge T. Then gnt and uart_start are high in cycle T+1, and uart_ready falls at T+2.
- A requester must hold req and req_data stable until it sees gnt. It may deassert req or change req_data in the cycle after gnt.
- Back-to-back frames: at most 1 IDLE cycle between uart_ready rising and the next uart_start.
- RX latency: uart_rcvd high in cycle C → rx_valid and uart_rxack high in C+1. uart_rcvd low by C+2; no second capture from the same frame.
- Reset mid-frame: the scheduler returns to IDLE and all outputs take their reset values. The `uart` is reset by the same signal.
- Simultaneous TX and RX activity is independent. Both paths advance in the same cycle with no interaction.

## Test plan
- Single request: req=4'b0100, req_data[2]=8'hA5.
  - gnt=4'b0100 and uart_start for exactly 1 cycle, uart_datatx=8'hA5.
  - `uart` tx line shows start bit, A5 LSB-first, stop bit; busy falls when uart_ready rises.
- Fairness: all four req held high, one word per requester.
  - Grant order 0,1,2,3,0,… (per the reset pointer).
  - Every uart_start starts exactly one frame; ≤1 idle cycle between frames.
- RX loopback: tx looped to rx, send 8'h3C, rx_ready=1.
  - rx_valid pulses once, rx_data=8'h3C.
  - uart_rxack is high exactly 1 cycle; rx_overrun=0.
- Overrun: rx_ready=0, receive 8'h11 then 8'h22.
  - rx_data stays 8'h11, rx_overrun=1, rx_valid=1.
  - Both frames are acked.
- Fault and reset:
  - Tie uart_ready=1 and request → tx_fault=1 three cycles after WAIT_BUSY is entered, then FSM returns to IDLE.
  - Assert reset mid-frame → all outputs take their reset values on the next edge.
